// File: rtl/seq_detect_prog_if.sv
// Serial detector bus: bit stream and pattern-load inputs, match/status outputs.
// master drives the stream and config; slave is the detector.
interface seq_detect_prog_if #(
  parameter int PAT_W = 5,
  parameter int CNT_W = 8
);
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             in_seq;
  logic             in_valid;
  logic             pat_load;
  logic [PAT_W-1:0] pat_data;
  logic [LEN_W-1:0] pat_len;
  logic             out_seq;
  logic [CNT_W-1:0] match_cnt;
  logic             armed;
  logic             cfg_err;

  modport master (
    output in_seq, in_valid, pat_load, pat_data, pat_len,
    input  out_seq, match_cnt, armed, cfg_err
  );

  modport slave (
    input  in_seq, in_valid, pat_load, pat_data, pat_len,
    output out_seq, match_cnt, armed, cfg_err
  );
endinterface

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector; out_seq pulses the cycle after the final bit, no backpressure.
// Define SEQ_DET_NONOVERLAP_EN to restart the window after every match (non-overlapping detection).
module seq_detect_prog #(
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b10110,
  parameter int               CNT_W   = 8
) (
  input logic              i_clk,
  input logic              i_reset,
  seq_detect_prog_if.slave bus
);
  localparam int LEN_W = $clog2(PAT_W + 1);

  typedef enum logic {S_FILL, S_HUNT} state_t;

  state_t           r_state;
  logic [PAT_W-1:0] r_pattern;
  logic [LEN_W-1:0] r_len;
  logic [PAT_W-1:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_seq;
  logic             r_cfg_err;

  logic [PAT_W-1:0] w_hist_n;
  logic [PAT_W-1:0] w_mask;
  logic [LEN_W:0]   w_fill_inc;
  logic [LEN_W-1:0] w_fill_nxt;
  logic             w_full;
  logic             w_match;
  logic             w_len_ok;

  assign w_hist_n   = (r_hist << 1) | PAT_W'(bus.in_seq);
  assign w_fill_inc = {1'b0, r_fill} + 1'b1;
  // fill+1 is kept one bit wider so the PAT_W clamp works even when PAT_W+1 is a power of two
  assign w_fill_nxt = (w_fill_inc > (LEN_W+1)'(PAT_W)) ? LEN_W'(PAT_W) : w_fill_inc[LEN_W-1:0];
  assign w_full     = (w_fill_inc >= {1'b0, r_len});
  assign w_len_ok   = (bus.pat_len != '0) && (bus.pat_len <= LEN_W'(PAT_W));

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
  end

  assign w_match = w_full && ((w_hist_n & w_mask) == (r_pattern & w_mask));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_FILL;
      r_pattern <= PATTERN;
      r_len     <= LEN_W'(PAT_W);
      r_hist    <= '0;
      r_fill    <= '0;
      r_cnt     <= '0;
      r_out_seq <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_out_seq <= 1'b0;
      r_cfg_err <= 1'b0;
      // A load owns the cycle: the concurrent stream bit is dropped either way
      if (bus.pat_load) begin
        if (w_len_ok) begin
          r_pattern <= bus.pat_data;
          r_len     <= bus.pat_len;
          r_hist    <= '0;
          r_fill    <= '0;
          r_cnt     <= '0;
          r_state   <= S_FILL;
        end else begin
          r_cfg_err <= 1'b1;
        end
      end else if (bus.in_valid) begin
        r_hist <= w_hist_n;
        r_fill <= w_fill_nxt;
        if (w_full) begin
          r_state <= S_HUNT;
        end
        if (w_match) begin
          r_out_seq <= 1'b1;
          if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
`ifdef SEQ_DET_NONOVERLAP_EN
          r_hist  <= '0;
          r_fill  <= '0;
          r_state <= S_FILL;
`endif
        end
      end
    end
  end

  assign bus.out_seq   = r_out_seq;
  assign bus.match_cnt = r_cnt;
  assign bus.armed     = (r_state == S_HUNT);
  assign bus.cfg_err   = r_cfg_err;
endmodule
